// File: rtl/ifns_decoder_pipe_if.sv
// Valid/ready stream bundle for the IFNS decoder: codewords in, decoded words out.
interface ifns_decoder_pipe_if #(
   parameter int CODE_W = 17,
   parameter int DATA_W = 12
);
   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] codein;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] dataout;
   logic              out_err;

   modport slave (
      input  in_valid, codein, out_ready,
      output in_ready, out_valid, dataout, out_err
   );

   modport master (
      output in_valid, codein, out_ready,
      input  in_ready, out_valid, dataout, out_err
   );
endinterface

// File: rtl/ifns_decoder_pipe.sv
// Pipelined IFNS (Fibonacci numeral system) codeword to binary decoder with
// valid/ready handshakes and a saturating out-of-range word counter.
module ifns_decoder_pipe #(
   parameter int CODE_W      = 17,
   parameter int DATA_W      = 12,
   parameter int PIPE_STAGES = 2,
   parameter int ERRCNT_W    = 16
) (
   input  logic                clock,
   input  logic                rst_n,
   ifns_decoder_pipe_if.slave  bus,
   input  logic                err_clr,
   output logic [ERRCNT_W-1:0] err_cnt
);
   localparam int SLICE = (CODE_W + PIPE_STAGES - 1) / PIPE_STAGES;

   // Weighted sum of the wires belonging to slice s; w_1 = w_2 = 1, w_k = w_(k-1) + w_(k-2).
   function automatic logic [31:0] slice_sum(input logic [CODE_W-1:0] code, input int s);
      logic [31:0] acc, w_prev, w_cur, w_next;
      acc    = '0;
      w_prev = '0;
      w_cur  = 32'd1;
      for (int i = 0; i < CODE_W; i++) begin
         if ((i >= s * SLICE) && (i < (s + 1) * SLICE) && code[i]) acc = acc + w_cur;
         w_next = w_prev + w_cur;
         w_prev = w_cur;
         w_cur  = w_next;
      end
      return acc;
   endfunction

   function automatic logic range_err(input logic [31:0] v);
      return (DATA_W < 32) && ((v >> DATA_W) != 32'd0);
   endfunction

   function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   logic              stall;
   logic [31:0]       fin_base;
   logic [CODE_W-1:0] fin_code;
   logic              fin_vld;
   logic [31:0]       value;

   assign stall        = bus.out_valid && !bus.out_ready;
   assign bus.in_ready = !stall;

   if (PIPE_STAGES == 1) begin : g_direct
      assign fin_base = '0;
      assign fin_code = bus.codein;
      assign fin_vld  = bus.in_valid;
   end else begin : g_pipe
      localparam int MID = PIPE_STAGES - 1;

      logic [31:0]       sum_p  [MID];
      logic [CODE_W-1:0] code_p [MID];
      logic              vld_p  [MID];
      logic [31:0]       part   [MID];

      always_comb begin
         part[0] = slice_sum(bus.codein, 0);
         for (int k = 1; k < MID; k++) part[k] = sum_p[k-1] + slice_sum(code_p[k-1], k);
      end

      // Stages 0..PIPE_STAGES-2: partial sum plus the raw codeword it still needs
      always_ff @(posedge clock or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k < MID; k++) vld_p[k] <= 1'b0;
         end else if (!stall) begin
            vld_p[0] <= bus.in_valid;
            for (int k = 1; k < MID; k++) vld_p[k] <= vld_p[k-1];
         end
      end

      always_ff @(posedge clock) begin
         if (!stall) begin
            sum_p[0]  <= part[0];
            code_p[0] <= bus.codein;
            for (int k = 1; k < MID; k++) begin
               sum_p[k]  <= part[k];
               code_p[k] <= code_p[k-1];
            end
         end
      end

      assign fin_base = sum_p[MID-1];
      assign fin_code = code_p[MID-1];
      assign fin_vld  = vld_p[MID-1];
   end

   assign value = fin_base + slice_sum(fin_code, PIPE_STAGES - 1);

   // Final stage: last slice, range check and output register
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.dataout   <= '0;
         bus.out_err   <= 1'b0;
      end else if (!stall) begin
         bus.out_valid <= fin_vld;
         if (fin_vld) begin
            bus.dataout <= value[DATA_W-1:0];
            bus.out_err <= range_err(value);
         end
      end
   end

   // Clear beats a same-cycle increment
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (err_clr) begin
         err_cnt <= '0;
      end else if (bus.out_valid && bus.out_ready && bus.out_err) begin
         err_cnt <= sat_inc(err_cnt);
      end
   end
endmodule

// File: tb/tb_ifns_decoder_pipe.sv
// Bench for ifns_decoder_pipe: four parameter sets run side by side against a
// Fibonacci-sum delay-line model, plus directed literal checks on the outputs.
`timescale 1ns/1ps
module tb_ifns_decoder_pipe;
   localparam int NCFG = 4;
   localparam int CW_T [NCFG] = '{17, 17, 17, 24};
   localparam int DW_T [NCFG] = '{12, 12, 12, 16};
   localparam int PS_T [NCFG] = '{2, 1, 5, 3};

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          mode = 0;
   logic        sh_valid = 1'b0;
   logic [63:0] sh_code = '0;
   logic        sh_ready = 1'b1;
   logic        sh_clr = 1'b0;

   always #5 clock = ~clock;

   task automatic chk(input int cfg, input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL cfg%0d %s: got %0d, expected %0d", cfg, nm, act, exp);
      end
   endtask

   function automatic longint fib_value(input logic [63:0] code, input int cw);
      longint f [47];
      longint s;
      f[1] = 1;
      f[2] = 1;
      for (int k = 3; k <= cw; k++) f[k] = f[k-1] + f[k-2];
      s = 0;
      for (int k = 1; k <= cw; k++) if (code[k-1]) s += f[k];
      return s;
   endfunction

   for (genvar c = 0; c < NCFG; c++) begin : g_cfg
      localparam int CW = CW_T[c];
      localparam int DW = DW_T[c];
      localparam int PS = PS_T[c];

      ifns_decoder_pipe_if #(.CODE_W(CW), .DATA_W(DW)) bus ();
      logic        err_clr;
      logic [15:0] err_cnt;

      ifns_decoder_pipe #(.CODE_W(CW), .DATA_W(DW), .PIPE_STAGES(PS), .ERRCNT_W(16)) dut (
         .clock   (clock),
         .rst_n   (rst_n),
         .bus     (bus),
         .err_clr (err_clr),
         .err_cnt (err_cnt)
      );

      bit     mv   [PS];
      longint mval [PS];
      int     mcnt = 0;
      int     ncyc = 0;
      int     acc_cyc [$];
      longint log_val [$];
      bit     log_err [$];
      int     log_lat [$];

      always @(negedge clock) begin : p_model
         logic [63:0] r;
         longint      lim;
         bit          stall_m;
         lim = longint'(1) << DW;
         if (!rst_n) begin
            for (int i = 0; i < PS; i++) begin
               mv[i]   = 1'b0;
               mval[i] = 0;
            end
            mcnt = 0;
            acc_cyc.delete();
            bus.in_valid  = 1'b0;
            bus.codein    = '0;
            bus.out_ready = 1'b1;
            err_clr       = 1'b0;
         end else begin
            chk(c, "in_ready", longint'(bus.in_ready), longint'(!(mv[PS-1] && !bus.out_ready)));
            chk(c, "out_valid", longint'(bus.out_valid), longint'(mv[PS-1]));
            if (mv[PS-1]) begin
               chk(c, "dataout", longint'(bus.dataout), mval[PS-1] % lim);
               chk(c, "out_err", longint'(bus.out_err), longint'(mval[PS-1] >= lim));
            end
            chk(c, "err_cnt", longint'(err_cnt), longint'(mcnt));

            if (mode == 1) begin
               r = {$urandom(), $urandom()};
               if ($urandom_range(15) == 0) r = '1;
               bus.in_valid  = ($urandom_range(9) < 7);
               bus.codein    = r[CW-1:0];
               bus.out_ready = ($urandom_range(9) < 7);
               err_clr       = ($urandom_range(63) == 0);
            end else begin
               bus.in_valid  = sh_valid;
               bus.codein    = sh_code[CW-1:0];
               bus.out_ready = sh_ready;
               err_clr       = sh_clr;
            end

            stall_m = mv[PS-1] && !bus.out_ready;
            if (err_clr) mcnt = 0;
            else if (mv[PS-1] && bus.out_ready && (mval[PS-1] >= lim) && (mcnt < 65535)) mcnt++;
            if (mv[PS-1] && bus.out_ready) begin
               log_val.push_back(longint'(bus.dataout));
               log_err.push_back(bus.out_err);
               log_lat.push_back(acc_cyc.size() > 0 ? ncyc - acc_cyc.pop_front() : -1);
            end
            if (!stall_m) begin
               for (int i = PS - 1; i > 0; i--) begin
                  mv[i]   = mv[i-1];
                  mval[i] = mval[i-1];
               end
               mv[0]   = bus.in_valid;
               mval[0] = fib_value(64'(bus.codein), CW);
               if (bus.in_valid) acc_cyc.push_back(ncyc);
            end
            ncyc++;
         end
      end
   end

   task automatic step(input bit v, input logic [63:0] code, input bit r, input bit clr);
      sh_valid = v;
      sh_code  = code;
      sh_ready = r;
      sh_clr   = clr;
      @(negedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 64'd0, 1'b1, 1'b0);
   endtask

   initial begin
      int          b0, b1, b2, b3;
      logic [63:0] t3c [4];
      longint      t3v [4];
      longint      t4v [3];
      t3c = '{64'h1, 64'h2, 64'h4, 64'h10000};
      t3v = '{1, 1, 2, 1597};
      t4v = '{2, 3, 5};

      rst_n = 1'b0;
      #1;
      chk(0, "rst_out_valid", longint'(g_cfg[0].bus.out_valid), 0);
      chk(0, "rst_dataout", longint'(g_cfg[0].bus.dataout), 0);
      chk(0, "rst_out_err", longint'(g_cfg[0].bus.out_err), 0);
      chk(0, "rst_err_cnt", longint'(g_cfg[0].err_cnt), 0);
      repeat (3) @(negedge clock);
      #1 rst_n = 1'b1;

      b0 = g_cfg[0].log_val.size();
      b1 = g_cfg[1].log_val.size();
      b2 = g_cfg[2].log_val.size();
      b3 = g_cfg[3].log_val.size();
      step(1'b1, 64'h15000, 1'b1, 1'b0);
      idle(8);
      chk(0, "t1_count", g_cfg[0].log_val.size(), b0 + 1);
      chk(0, "t1_data", g_cfg[0].log_val[b0], 2440);
      chk(0, "t1_err", longint'(g_cfg[0].log_err[b0]), 0);
      chk(0, "t1_lat", g_cfg[0].log_lat[b0], 2);
      chk(1, "t1_lat", g_cfg[1].log_lat[b1], 1);
      chk(2, "t1_lat", g_cfg[2].log_lat[b2], 5);
      chk(3, "t1_data", g_cfg[3].log_val[b3], 2440);

      b0 = g_cfg[0].log_val.size();
      b2 = g_cfg[2].log_val.size();
      b3 = g_cfg[3].log_val.size();
      for (int i = 0; i < 4; i++) step(1'b1, t3c[i], 1'b1, 1'b0);
      idle(8);
      chk(0, "t3_count", g_cfg[0].log_val.size(), b0 + 4);
      for (int i = 0; i < 4; i++) begin
         chk(0, "t3_data", g_cfg[0].log_val[b0 + i], t3v[i]);
         chk(0, "t3_lat", g_cfg[0].log_lat[b0 + i], 2);
         chk(2, "t3_data", g_cfg[2].log_val[b2 + i], t3v[i]);
         chk(3, "t3_data", g_cfg[3].log_val[b3 + i], t3v[i]);
      end

      b0 = g_cfg[0].log_val.size();
      b3 = g_cfg[3].log_val.size();
      step(1'b1, 64'h1FFFF, 1'b1, 1'b0);
      idle(8);
      chk(0, "t2_data", g_cfg[0].log_val[b0], 84);
      chk(0, "t2_err", longint'(g_cfg[0].log_err[b0]), 1);
      chk(0, "t2_err_cnt", longint'(g_cfg[0].err_cnt), 1);
      chk(3, "t2_data", g_cfg[3].log_val[b3], 4180);
      chk(3, "t2_err", longint'(g_cfg[3].log_err[b3]), 0);
      chk(3, "t2_err_cnt", longint'(g_cfg[3].err_cnt), 0);

      b0 = g_cfg[0].log_val.size();
      b2 = g_cfg[2].log_val.size();
      step(1'b1, 64'h3, 1'b1, 1'b0);
      step(1'b1, 64'h8, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 64'h10, 1'b0, 1'b0);
         chk(0, "t4_in_ready", longint'(g_cfg[0].bus.in_ready), 0);
         chk(0, "t4_out_valid", longint'(g_cfg[0].bus.out_valid), 1);
         chk(0, "t4_hold_data", longint'(g_cfg[0].bus.dataout), 2);
      end
      step(1'b1, 64'h10, 1'b1, 1'b0);
      idle(8);
      chk(0, "t4_count", g_cfg[0].log_val.size(), b0 + 3);
      for (int i = 0; i < 3; i++) begin
         chk(0, "t4_order", g_cfg[0].log_val[b0 + i], t4v[i]);
         chk(2, "t4_order", g_cfg[2].log_val[b2 + i], t4v[i]);
      end

      for (int i = 0; i < 65537; i++) step(1'b1, '1, 1'b1, 1'b0);
      repeat (4) step(1'b1, '1, 1'b1, 1'b0);
      chk(0, "t5_saturate", longint'(g_cfg[0].err_cnt), 65535);
      step(1'b1, '1, 1'b1, 1'b1);
      @(posedge clock);
      #1;
      chk(0, "t5_clear", longint'(g_cfg[0].err_cnt), 0);
      idle(8);

      sh_valid = 1'b0;
      sh_code  = '0;
      sh_ready = 1'b1;
      sh_clr   = 1'b0;
      mode = 1;
      repeat (2000) @(negedge clock);
      @(posedge clock);
      #2 rst_n = 1'b0;
      #1;
      chk(0, "t6_out_valid", longint'(g_cfg[0].bus.out_valid), 0);
      chk(0, "t6_dataout", longint'(g_cfg[0].bus.dataout), 0);
      chk(0, "t6_out_err", longint'(g_cfg[0].bus.out_err), 0);
      chk(0, "t6_err_cnt", longint'(g_cfg[0].err_cnt), 0);
      chk(2, "t6_out_valid", longint'(g_cfg[2].bus.out_valid), 0);
      repeat (2) @(negedge clock);
      #1 rst_n = 1'b1;
      repeat (2000) @(negedge clock);
      #1 mode = 0;
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
